// File: rtl/mfm_writer_if.sv
// mfm_writer_if
// Bundles the byte-feed handshake and the write-head outputs of mfm_writer.
//   iWG        write gate (1 = serialize, 0 = idle/abort)
//   iDATA      byte to write
//   iMARK      00 normal, 01 A1 mark, 10 C2 mark, 11 normal
//   iLOAD      one-cycle strobe into the holding register
//   oREQ       holding register empty
//   oWD        write-data pulse to the drive
//   oBUSY      serializer running
//   oLOST      sticky underrun flag
//   state_dbg  FSM state (0 = IDLE, 1 = RUN)
// Handshake: a byte is accepted on a rising iCLK edge where iLOAD=1 and
// oREQ=1; iLOAD with oREQ=0 is ignored, and iDATA/iMARK only need to be
// valid in the accepting cycle.
interface mfm_writer_if;
  logic       iWG;
  logic [7:0] iDATA;
  logic [1:0] iMARK;
  logic       iLOAD;
  logic       oREQ;
  logic       oWD;
  logic       oBUSY;
  logic       oLOST;
  logic       state_dbg;

  modport master (
    output iWG, iDATA, iMARK, iLOAD,
    input  oREQ, oWD, oBUSY, oLOST, state_dbg
  );

  modport slave (
    input  iWG, iDATA, iMARK, iLOAD,
    output oREQ, oWD, oBUSY, oLOST, state_dbg
  );
endinterface

// File: rtl/mfm_writer.sv
// mfm_writer
// MFM serializer for a floppy write head. Bytes (or A1/C2 sync marks) are
// taken from a one-deep holding register, MFM-encoded into 16 half-cells
// and emitted MSB first as fixed-width oWD pulses.
// Ports:
//   iCLK  single clock
//   iRST  asynchronous active-high reset
//   bus   mfm_writer_if.slave (iWG, iDATA, iMARK, iLOAD, oREQ, oWD, oBUSY,
//         oLOST, state_dbg)
// Parameters:
//   HALF_CELL_CLKS  iCLK cycles per half-cell
//   WPULSE_CLKS     write pulse width in iCLK cycles
//   PRECOMP_CLKS    precompensation shift in iCLK cycles
// Optional feature: define MFM_WRITER_PRECOMP_EN to enable write
// precompensation (stream delayed two half-cells, pulses shifted early/late).
module mfm_writer #(
  parameter int HALF_CELL_CLKS = 32,
  parameter int WPULSE_CLKS    = 4,
  parameter int PRECOMP_CLKS   = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  mfm_writer_if.slave bus
);

  localparam int CW = (HALF_CELL_CLKS > 1) ? $clog2(HALF_CELL_CLKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CELL_CLKS - 1);

  if (WPULSE_CLKS < 1 || WPULSE_CLKS > HALF_CELL_CLKS / 4 || PRECOMP_CLKS < 0 ||
      2 * PRECOMP_CLKS + WPULSE_CLKS > HALF_CELL_CLKS) begin : g_bad_params
    $error("mfm_writer: pulse width / precomp do not fit in a half-cell");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          full_q;
  logic [7:0]    hdata_q;
  logic [1:0]    hmark_q;
  logic [CW-1:0] clk_cnt_q;
  logic [3:0]    cell_cnt_q;
  logic [15:0]   word_q;
  logic          prev_q;
  logic          wd_q;
  logic          lost_q;

  logic          run_active;
  logic          byte_start;
  logic          load_ok;
  logic [31:0]   cnt_ext;
  logic [15:0]   enc_word;
  logic          enc_prev;
  logic [7:0]    enc_data;
  logic          enc_p;
  logic          wd_next;

  // Serializer only advances while the gate is still high; the cycle in
  // which iWG is sampled low is already treated as an abort.
  assign run_active = (state_q == RUN) && bus.iWG;
  assign byte_start = run_active && (cell_cnt_q == 4'd0) && (clk_cnt_q == '0);
  assign load_ok    = bus.iLOAD && !full_q;
  assign cnt_ext    = 32'(clk_cnt_q);

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.iWG)  state_d = RUN;
      RUN:     if (!bus.iWG) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Encoder for the word about to start. An empty holding register encodes
  // 0x00 as a normal byte (underrun). Marks ignore the previous data bit.
  always_comb begin
    enc_word = '0;
    enc_prev = prev_q;
    enc_data = full_q ? hdata_q : 8'h00;
    enc_p    = prev_q;
    if (full_q && hmark_q == 2'b01) begin
      enc_word = 16'h4489;
      enc_prev = 1'b1;
    end else if (full_q && hmark_q == 2'b10) begin
      enc_word = 16'h5224;
      enc_prev = 1'b0;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        enc_word[2*i+1] = ~enc_p & ~enc_data[i];
        enc_word[2*i]   = enc_data[i];
        enc_p           = enc_data[i];
      end
      enc_prev = enc_data[0];
    end
  end

`ifdef MFM_WRITER_PRECOMP_EN
  // hist_q holds the most recent cells (bit 0 newest); hval_q marks which
  // of them belong to the current write so pre-start cells never count as
  // neighbours. The cell actually written lags the encoder by two cells.
  logic [4:0]  hist_q;
  logic [4:0]  hval_q;
  logic        cur_bit;
  logic        center, before2, before2_ok, after2;
  logic        early, late;
  logic [31:0] offset;

  assign cur_bit = (cell_cnt_q == 4'd0) ? enc_word[15] : word_q[4'd15 - cell_cnt_q];

  always_comb begin
    // In the cell-start cycle the history has not shifted yet, so the
    // window sits one position lower and the look-ahead is the new cell.
    if (clk_cnt_q == '0) begin
      center     = hist_q[1];
      before2    = hist_q[3];
      before2_ok = hval_q[3];
      after2     = cur_bit;
    end else begin
      center     = hist_q[2];
      before2    = hist_q[4];
      before2_ok = hval_q[4];
      after2     = hist_q[0];
    end
    early  = before2_ok && before2 && !after2;
    late   = before2_ok && !before2 && after2;
    offset = early ? 32'd0 : (late ? 32'(2 * PRECOMP_CLKS) : 32'(PRECOMP_CLKS));
    wd_next = run_active && center && (cnt_ext >= offset) &&
              (cnt_ext < offset + 32'(WPULSE_CLKS));
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hist_q <= '0;
      hval_q <= '0;
    end else if (!run_active) begin
      hist_q <= '0;
      hval_q <= '0;
    end else if (clk_cnt_q == '0) begin
      hist_q <= {hist_q[3:0], cur_bit};
      hval_q <= {hval_q[3:0], 1'b1};
    end
  end
`else
  logic bit_now;

  // Cell 0 of a word comes straight from the encoder: word_q only holds it
  // from the following cycle on.
  assign bit_now = (cell_cnt_q == 4'd0 && clk_cnt_q == '0) ? enc_word[15]
                                                            : word_q[4'd15 - cell_cnt_q];

  always_comb begin
    wd_next = run_active && bit_now && (cnt_ext < 32'(WPULSE_CLKS));
  end
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      full_q     <= 1'b0;
      hdata_q    <= '0;
      hmark_q    <= '0;
      clk_cnt_q  <= '0;
      cell_cnt_q <= '0;
      word_q     <= '0;
      prev_q     <= 1'b0;
      wd_q       <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      wd_q <= wd_next;

      if (run_active) begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_q  <= '0;
          cell_cnt_q <= cell_cnt_q + 4'd1;
        end else begin
          clk_cnt_q <= clk_cnt_q + 1'b1;
        end
      end else begin
        clk_cnt_q  <= '0;
        cell_cnt_q <= '0;
      end

      if (state_q == IDLE) begin
        prev_q <= 1'b0;
        if (bus.iWG) lost_q <= 1'b0;
      end else if (byte_start) begin
        word_q <= enc_word;
        prev_q <= enc_prev;
        if (!full_q) lost_q <= 1'b1;
      end

      // Abort empties the holding register; a load accepted in a byte-start
      // cycle (only possible on underrun) is kept for the next word.
      if (state_q == RUN && !bus.iWG) begin
        full_q <= 1'b0;
      end else if (load_ok) begin
        full_q  <= 1'b1;
        hdata_q <= bus.iDATA;
        hmark_q <= bus.iMARK;
      end else if (byte_start) begin
        full_q <= 1'b0;
      end
    end
  end

  assign bus.oREQ      = ~full_q;
  assign bus.oWD       = wd_q;
  assign bus.oBUSY     = (state_q == RUN);
  assign bus.oLOST     = lost_q;
  assign bus.state_dbg = (state_q == RUN);

endmodule
